sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// Registered-pin controller for NUM_CHIPS 16-bit asynchronous SRAMs sharing address/control lines.
// Define SRAM_CTRL_TURNAROUND_EN to insert a one-cycle bus turnaround state after every write.
module sram_ctrl #(
    parameter int NUM_CHIPS = 3,
    parameter int ADDR_W    = 20,
    parameter int RD_WAIT   = 2,
    parameter int WR_WAIT   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   wr,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [2*NUM_CHIPS-1:0] be,
    input  logic [16*NUM_CHIPS-1:0] wdata,
    output logic                   ready,
    output logic                   ack,
    output logic [16*NUM_CHIPS-1:0] rdata,
    inout  wire  [16*NUM_CHIPS-1:0] SRAM_DATA,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    output logic [NUM_CHIPS-1:0]   SRAM_CE_N,
    output logic [NUM_CHIPS-1:0]   SRAM_WE_N,
    output logic [NUM_CHIPS-1:0]   SRAM_OE_N,
    output logic [NUM_CHIPS-1:0]   SRAM_UB_N,
    output logic [NUM_CHIPS-1:0]   SRAM_LB_N,
    output logic [2:0]             o_dbg_state
);

    // Handshake: a request is taken on any cycle where req and ready are both 1;
    // ack pulses for exactly one cycle when the access has finished on the pins.
`ifdef SRAM_CTRL_TURNAROUND_EN
    typedef enum logic [2:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE, TURN
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
    } state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    r_ack;
    logic [16*NUM_CHIPS-1:0] r_rdata;
    logic [16*NUM_CHIPS-1:0] r_wdata;
    logic [2*NUM_CHIPS-1:0]  r_be;
    logic [ADDR_W-1:0]       r_sram_addr;
    logic [NUM_CHIPS-1:0]    r_ce_n, r_we_n, r_oe_n, r_ub_n, r_lb_n;
    logic [2*NUM_CHIPS-1:0]  r_drv;
`ifdef SRAM_CTRL_TURNAROUND_EN
    logic                    r_wr;
`endif

    logic                    w_accept;
    logic [2*NUM_CHIPS-1:0]  w_be_eff;
    logic [NUM_CHIPS-1:0]    w_ce_nxt, w_we_nxt, w_oe_nxt, w_ub_nxt, w_lb_nxt;
    logic [2*NUM_CHIPS-1:0]  w_drv_nxt;

    assign ready       = (r_state == IDLE) && !rst;
    assign w_accept    = (r_state == IDLE) && req;
    assign ack         = r_ack;
    assign rdata       = r_rdata;
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_CE_N   = r_ce_n;
    assign SRAM_WE_N   = r_we_n;
    assign SRAM_OE_N   = r_oe_n;
    assign SRAM_UB_N   = r_ub_n;
    assign SRAM_LB_N   = r_lb_n;
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (!wr) begin
                        w_state_nxt = RD;
                        w_cnt_nxt   = 4'(RD_WAIT);
                    end else if (be == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = WR_SETUP;
                    end
                end
            end
            RD: begin
                if (r_cnt == '0) w_state_nxt = DONE;
                else             w_cnt_nxt   = r_cnt - 4'd1;
            end
            WR_SETUP: begin
                w_state_nxt = WR_PULSE;
                w_cnt_nxt   = 4'(WR_WAIT);
            end
            WR_PULSE: begin
                if (r_cnt == '0) w_state_nxt = WR_HOLD;
                else             w_cnt_nxt   = r_cnt - 4'd1;
            end
            WR_HOLD: w_state_nxt = DONE;
`ifdef SRAM_CTRL_TURNAROUND_EN
            DONE:    w_state_nxt = r_wr ? TURN : IDLE;
            TURN:    w_state_nxt = IDLE;
`else
            DONE:    w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pin values are computed for the state being entered, then registered,
    // so the strobes line up with the state and never glitch from the inputs.
    assign w_be_eff = (r_state == IDLE) ? be : r_be;

    always_comb begin
        w_ce_nxt  = '1;
        w_we_nxt  = '1;
        w_oe_nxt  = '1;
        w_ub_nxt  = '1;
        w_lb_nxt  = '1;
        w_drv_nxt = '0;
        case (w_state_nxt)
            RD: begin
                w_ce_nxt = '0;
                w_oe_nxt = '0;
                w_ub_nxt = '0;
                w_lb_nxt = '0;
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                for (int k = 0; k < NUM_CHIPS; k++) begin
                    w_ce_nxt[k] = ~|w_be_eff[2*k +: 2];
                    w_ub_nxt[k] = ~w_be_eff[2*k+1];
                    w_lb_nxt[k] = ~w_be_eff[2*k];
                end
                w_drv_nxt = w_be_eff;
                if (w_state_nxt == WR_PULSE) w_we_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_sram_addr <= '0;
            r_ce_n      <= '1;
            r_we_n      <= '1;
            r_oe_n      <= '1;
            r_ub_n      <= '1;
            r_lb_n      <= '1;
            r_drv       <= '0;
`ifdef SRAM_CTRL_TURNAROUND_EN
            r_wr        <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= (w_state_nxt == DONE);
            r_ce_n  <= w_ce_nxt;
            r_we_n  <= w_we_nxt;
            r_oe_n  <= w_oe_nxt;
            r_ub_n  <= w_ub_nxt;
            r_lb_n  <= w_lb_nxt;
            r_drv   <= w_drv_nxt;
            if (w_accept) begin
                r_sram_addr <= addr;
                r_be        <= be;
                r_wdata     <= wdata;
`ifdef SRAM_CTRL_TURNAROUND_EN
                r_wr        <= wr;
`endif
            end
            if (r_state == RD && r_cnt == '0) r_rdata <= SRAM_DATA;
        end
    end

    genvar gi;
    for (gi = 0; gi < 2*NUM_CHIPS; gi++) begin : g_bus
        assign SRAM_DATA[8*gi +: 8] = r_drv[gi] ? r_wdata[8*gi +: 8] : 8'bz;
    end

endmodule
